// File: rtl/bp_pkg.sv
// Shared branch-predictor definitions: 2-bit counter encoding,
// transition rule and PC-to-index helper.
package bp_pkg;

  localparam logic [1:0] NTS = 2'b00;
  localparam logic [1:0] NTW = 2'b01;
  localparam logic [1:0] TW  = 2'b10;
  localparam logic [1:0] TS  = 2'b11;

  // Weak-not-taken jumps straight to strong-taken on a taken outcome
  function automatic logic [1:0] bp_next(
    input logic [1:0] state,
    input logic       taken
  );
    logic [1:0] n;
    n = NTS;
    case (state)
      NTS:     n = taken ? NTW : NTS;
      NTW:     n = taken ? TS  : NTS;
      TW:      n = taken ? TS  : NTS;
      default: n = taken ? TS  : TW;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] bp_idx(
    input logic [31:0] pc,
    input int unsigned lsb
  );
    return pc >> lsb;
  endfunction

endpackage

// File: rtl/bht_entry_next.sv
// Combinational next-state for one 2-bit predictor counter.
// Also used by the single-entry FSM so both share one rule.
module bht_entry_next
  import bp_pkg::*;
(
  input  logic [1:0] state,
  input  logic       taken,
  output logic [1:0] next
);

  assign next = bp_next(state, taken);

endmodule

// File: rtl/bht_predictor.sv
// Branch history table: 2-bit counters indexed by PC, 1-cycle
// lookup with write-first bypass, plus update/mispredict stats.
module bht_predictor
  import bp_pkg::*;
#(
  parameter int IDX_BITS = 6,
  parameter int PC_LSB   = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [31:0]      lookup_pc,
  output logic             pred_valid,
  output logic             pred_taken,
  output logic [1:0]       pred_state,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic             upd_pred_taken,
  output logic [CNT_W-1:0] upd_count,
  output logic [CNT_W-1:0] mispred_count
);

  localparam int N = 1 << IDX_BITS;
  localparam logic [CNT_W-1:0] CMAX = '1;

  typedef logic [IDX_BITS-1:0] idx_t;

  logic [1:0] tbl [N];
  idx_t       lidx;
  idx_t       uidx;
  logic [1:0] cur;
  logic [1:0] nxt;
  logic [1:0] rd;

  assign lidx = idx_t'(bp_idx(lookup_pc, PC_LSB));
  assign uidx = idx_t'(bp_idx(upd_pc, PC_LSB));
  assign cur  = tbl[uidx];

  bht_entry_next u_next (
    .state (cur),
    .taken (upd_taken),
    .next  (nxt)
  );

  // Write-first: a same-index update is visible to this lookup
  always_comb begin
    rd = tbl[lidx];
    if (upd_valid && (uidx == lidx)) rd = nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) tbl[i] <= NTS;
    end else if (upd_valid) begin
      tbl[uidx] <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid <= 1'b0;
      pred_state <= NTS;
    end else begin
      pred_valid <= lookup_valid;
      if (lookup_valid) pred_state <= rd;
    end
  end

  assign pred_taken = pred_state[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_count     <= '0;
      mispred_count <= '0;
    end else if (upd_valid) begin
      if (upd_count != CMAX) upd_count <= upd_count + 1'b1;
      if ((upd_taken != upd_pred_taken) && (mispred_count != CMAX))
        mispred_count <= mispred_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_bht_predictor.sv
// Directed self-checking bench for bht_predictor, with a
// second 4-bit-counter instance to exercise saturation.
module tb_bht_predictor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        lookup_valid = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_pred_taken = 1'b0;

  logic        pred_valid, pred_taken;
  logic [1:0]  pred_state;
  logic [15:0] upd_count, mispred_count;

  logic        pv4, pt4;
  logic [1:0]  ps4;
  logic [3:0]  uc4, mc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bht_predictor dut (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken),
    .pred_state(pred_state),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_pred_taken(upd_pred_taken),
    .upd_count(upd_count), .mispred_count(mispred_count)
  );

  bht_predictor #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pv4), .pred_taken(pt4),
    .pred_state(ps4),
    .upd_valid(upd_valid), .upd_pc(upd_pc),
    .upd_taken(upd_taken), .upd_pred_taken(upd_pred_taken),
    .upd_count(uc4), .mispred_count(mc4)
  );

  task automatic cyc(input logic lv, input logic [31:0] lpc,
                     input logic uv, input logic [31:0] upc,
                     input logic ut, input logic upt);
    @(negedge clk);
    lookup_valid   = lv;
    lookup_pc      = lv ? lpc : 32'hxxxx_xxxx;
    upd_valid      = uv;
    upd_pc         = uv ? upc : 32'hxxxx_xxxx;
    upd_taken      = ut;
    upd_pred_taken = upt;
    @(posedge clk);
    #1;
    lookup_valid = 1'b0;
    upd_valid    = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({pred_valid, pred_taken, pred_state} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_pred got %b%b%b want 0000",
               pred_valid, pred_taken, pred_state);
    end
    checks++;
    if (upd_count !== 16'd0 || mispred_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%0d want 0/0",
               upd_count, mispred_count);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 32'hdead_0044, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if ({pred_valid, pred_taken, pred_state} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_lookup got %b%b%b want 1000",
               pred_valid, pred_taken, pred_state);
    end
  endtask

  task automatic test_train();
    logic [1:0] exp [4] = '{2'b01, 2'b11, 2'b11, 2'b11};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b1, 32'h100, 1'b1, 1'b0);
      cyc(1'b1, 32'h100, 1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (pred_state !== exp[i] || pred_taken !== exp[i][1]) begin
        errors++;
        $display("FAIL train%0d got %b/%b want %b", i,
                 pred_state, pred_taken, exp[i]);
      end
    end
  endtask

  task automatic test_decay();
    logic [1:0] exp [4] = '{2'b10, 2'b00, 2'b01, 2'b00};
    logic       tk  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b1, 32'h100, tk[i], 1'b1);
      cyc(1'b1, 32'h100, 1'b0, '0, 1'b0, 1'b0);
      checks++;
      if (pred_state !== exp[i] || pred_taken !== exp[i][1]) begin
        errors++;
        $display("FAIL decay%0d got %b/%b want %b", i,
                 pred_state, pred_taken, exp[i]);
      end
    end
  endtask

  task automatic test_bypass();
    cyc(1'b0, '0, 1'b1, 32'h200, 1'b1, 1'b0);
    cyc(1'b1, 32'h300, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (pred_state !== 2'b01) begin
      errors++;
      $display("FAIL alias got %b want 01", pred_state);
    end
    cyc(1'b1, 32'h200, 1'b1, 32'h200, 1'b1, 1'b0);
    checks++;
    if (pred_state !== 2'b11 || pred_taken !== 1'b1) begin
      errors++;
      $display("FAIL bypass_same got %b want 11", pred_state);
    end
    cyc(1'b1, 32'h204, 1'b1, 32'h208, 1'b1, 1'b0);
    checks++;
    if (pred_state !== 2'b00) begin
      errors++;
      $display("FAIL bypass_diff got %b want 00", pred_state);
    end
    cyc(1'b1, 32'h208, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (pred_state !== 2'b01) begin
      errors++;
      $display("FAIL indep_upd got %b want 01", pred_state);
    end
    cyc(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (pred_valid !== 1'b0 || pred_state !== 2'b01) begin
      errors++;
      $display("FAIL hold got v=%b s=%b want v=0 s=01",
               pred_valid, pred_state);
    end
  endtask

  task automatic test_counters();
    logic [9:0] tk = 10'b1011001110;
    logic [9:0] pr = 10'b1001101100;
    do_reset();
    for (int i = 0; i < 10; i++)
      cyc(1'b0, '0, 1'b1, 32'(i * 4), tk[i], pr[i]);
    checks++;
    if (upd_count !== 16'd10 || mispred_count !== 16'd3) begin
      errors++;
      $display("FAIL cnt10 got %0d/%0d want 10/3",
               upd_count, mispred_count);
    end
    for (int i = 0; i < 15; i++)
      cyc(1'b0, '0, 1'b1, 32'h40, 1'b1, 1'b0);
    checks++;
    if (upd_count !== 16'd25 || mispred_count !== 16'd18) begin
      errors++;
      $display("FAIL cnt25 got %0d/%0d want 25/18",
               upd_count, mispred_count);
    end
    checks++;
    if (uc4 !== 4'd15 || mc4 !== 4'd15) begin
      errors++;
      $display("FAIL sat4 got %0d/%0d want 15/15", uc4, mc4);
    end
  endtask

  task automatic test_reset_inflight();
    cyc(1'b0, '0, 1'b1, 32'h80, 1'b1, 1'b0);
    cyc(1'b0, '0, 1'b1, 32'h80, 1'b1, 1'b0);
    cyc(1'b1, 32'h80, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (pred_state !== 2'b11) begin
      errors++;
      $display("FAIL pre_rst got %b want 11", pred_state);
    end
    @(negedge clk);
    lookup_valid = 1'b1;
    lookup_pc    = 32'h80;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (pred_valid !== 1'b0 || pred_state !== 2'b00) begin
      errors++;
      $display("FAIL inflight got v=%b s=%b want 0/00",
               pred_valid, pred_state);
    end
    lookup_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 32'h80, 1'b0, '0, 1'b0, 1'b0);
    checks++;
    if (pred_valid !== 1'b1 || pred_state !== 2'b00) begin
      errors++;
      $display("FAIL post_rst got v=%b s=%b want 1/00",
               pred_valid, pred_state);
    end
  endtask

  initial begin
    test_reset();
    test_train();
    test_decay();
    test_bypass();
    test_counters();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
